// File: rtl/md_defs_pkg.sv
// ============================================================================
// Module   : md_defs (package)
// Summary  : Multiply/divide opcode encodings and default latencies shared by
//            md_unit, the decoder and the hazard unit.
// Revision : 1.0
// ============================================================================
`default_nettype none

package md_defs;

    typedef enum logic [3:0] {
        MD_NONE  = 4'd0,
        MD_MULT  = 4'd1,
        MD_MULTU = 4'd2,
        MD_DIV   = 4'd3,
        MD_DIVU  = 4'd4,
        MD_MTHI  = 4'd5,
        MD_MTLO  = 4'd6,
        MD_MADD  = 4'd7,
        MD_MADDU = 4'd8,
        MD_MSUB  = 4'd9,
        MD_MSUBU = 4'd10
    } md_op_e;

    localparam int MD_MULT_LAT = 5;
    localparam int MD_DIV_LAT  = 10;

endpackage

`default_nettype wire

// File: rtl/md_unit.sv
// ============================================================================
// Module   : md_unit
// Summary  : EX-stage multiply/divide unit with architectural HI/LO and a
//            multi-cycle busy window. Define MDU_MADD_EN to add MADD/MADDU/
//            MSUB/MSUBU (opcodes 7-10); otherwise those codes act as NONE.
// Revision : 1.0
// ============================================================================
`default_nettype none

module md_unit
    import md_defs::*;
#(
    parameter int MULT_LAT = MD_MULT_LAT,
    parameter int DIV_LAT  = MD_DIV_LAT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] numa,
    input  logic [31:0] numb,
    input  logic [3:0]  mdop,
    input  logic        start,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [3:0] c_MULT_CNT = 4'(MULT_LAT);
    localparam logic [3:0] c_DIV_CNT  = 4'(DIV_LAT);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_e;

    state_e      r_state;
    logic [3:0]  r_cnt;
    logic [31:0] r_phi;
    logic [31:0] r_plo;

    logic        w_accept;
    logic        w_is_div;
    logic [63:0] w_res;
    logic [63:0] w_sprod;
    logic [63:0] w_uprod;

    always_comb begin
        w_sprod  = $signed({{32{numa[31]}}, numa}) * $signed({{32{numb[31]}}, numb});
        w_uprod  = {32'd0, numa} * {32'd0, numb};
        w_accept = 1'b0;
        w_is_div = 1'b0;
        // Default keeps HI/LO, which is also the divide-by-zero outcome.
        w_res    = {hi, lo};
        case (mdop)
            MD_MULT: begin
                w_accept = 1'b1;
                w_res    = w_sprod;
            end
            MD_MULTU: begin
                w_accept = 1'b1;
                w_res    = w_uprod;
            end
            MD_DIV: begin
                w_accept = 1'b1;
                w_is_div = 1'b1;
                if (numb != 32'd0) begin
                    // The one overflowing signed quotient wraps to itself.
                    if (numa == 32'h8000_0000 && numb == 32'hFFFF_FFFF)
                        w_res = {32'd0, 32'h8000_0000};
                    else
                        w_res = {32'($signed(numa) % $signed(numb)),
                                 32'($signed(numa) / $signed(numb))};
                end
            end
            MD_DIVU: begin
                w_accept = 1'b1;
                w_is_div = 1'b1;
                if (numb != 32'd0)
                    w_res = {numa % numb, numa / numb};
            end
`ifdef MDU_MADD_EN
            MD_MADD: begin
                w_accept = 1'b1;
                w_res    = {hi, lo} + w_sprod;
            end
            MD_MADDU: begin
                w_accept = 1'b1;
                w_res    = {hi, lo} + w_uprod;
            end
            MD_MSUB: begin
                w_accept = 1'b1;
                w_res    = {hi, lo} - w_sprod;
            end
            MD_MSUBU: begin
                w_accept = 1'b1;
                w_res    = {hi, lo} - w_uprod;
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_phi   <= 32'd0;
            r_plo   <= 32'd0;
            busy    <= 1'b0;
            hi      <= 32'd0;
            lo      <= 32'd0;
        end else if (r_state == S_IDLE) begin
            if (start) begin
                if (w_accept) begin
                    r_phi   <= w_res[63:32];
                    r_plo   <= w_res[31:0];
                    r_cnt   <= w_is_div ? c_DIV_CNT : c_MULT_CNT;
                    busy    <= 1'b1;
                    r_state <= S_BUSY;
                end else if (mdop == MD_MTHI) begin
                    hi <= numa;
                end else if (mdop == MD_MTLO) begin
                    lo <= numa;
                end
            end
        end else begin
            r_cnt <= r_cnt - 4'd1;
            if (r_cnt == 4'd1) begin
                hi      <= r_phi;
                lo      <= r_plo;
                busy    <= 1'b0;
                r_state <= S_IDLE;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_md_unit.sv
// ============================================================================
// Module   : tb_md_unit
// Summary  : Self-checking bench for md_unit: reference model compared every
//            cycle plus hand-computed expectations. Honours MDU_MADD_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_md_unit;
    import md_defs::*;

`ifdef MDU_MADD_EN
    localparam bit MADD_EN = 1'b1;
`else
    localparam bit MADD_EN = 1'b0;
`endif

    logic        clk   = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [3:0]  mdop  = 4'd0;
    logic [31:0] numa  = 32'd0;
    logic [31:0] numb  = 32'd0;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    md_unit dut (
        .clk   (clk),
        .reset (reset),
        .numa  (numa),
        .numb  (numb),
        .mdop  (mdop),
        .start (start),
        .busy  (busy),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: architectural HI/LO, remaining busy cycles, pending result.
    logic [31:0] m_hi   = 32'd0;
    logic [31:0] m_lo   = 32'd0;
    int          m_rem  = 0;
    logic [63:0] m_pend = 64'd0;

    function automatic logic [63:0] model_result(input logic [3:0] op, input logic [31:0] a,
                                                 input logic [31:0] b, input logic [63:0] acc);
        longint          sa = longint'($signed(a));
        longint          sb = longint'($signed(b));
        longint unsigned ua = {32'd0, a};
        longint unsigned ub = {32'd0, b};
        longint          q;
        longint          r;
        case (op)
            4'd1: return sa * sb;
            4'd2: return ua * ub;
            4'd3: begin
                if (b == 32'd0) return acc;
                q = sa / sb;
                r = sa - q * sb;
                return {r[31:0], q[31:0]};
            end
            4'd4: begin
                if (b == 32'd0) return acc;
                return {a % b, a / b};
            end
            4'd7:  return acc + 64'(sa * sb);
            4'd8:  return acc + ua * ub;
            4'd9:  return acc - 64'(sa * sb);
            4'd10: return acc - ua * ub;
            default: return acc;
        endcase
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_hi  <= 32'd0;
            m_lo  <= 32'd0;
            m_rem <= 0;
        end else if (m_rem > 0) begin
            m_rem <= m_rem - 1;
            if (m_rem == 1) {m_hi, m_lo} <= m_pend;
        end else if (start) begin
            if ((mdop >= 4'd1 && mdop <= 4'd4) || (MADD_EN && mdop >= 4'd7 && mdop <= 4'd10)) begin
                m_pend <= model_result(mdop, numa, numb, {m_hi, m_lo});
                m_rem  <= (mdop == 4'd3 || mdop == 4'd4) ? 10 : 5;
            end else if (mdop == 4'd5) begin
                m_hi <= numa;
            end else if (mdop == 4'd6) begin
                m_lo <= numa;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_busy", {31'd0, busy}, {31'd0, m_rem > 0});
            check("model_hi", hi, m_hi);
            check("model_lo", lo, m_lo);
        end
    end

    task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1;
        mdop  = op;
        numa  = a;
        numb  = b;
        @(posedge clk); #1;
        start = 1'b0;
        mdop  = MD_NONE;
        numa  = $urandom;
        numb  = $urandom;
    endtask

    // Counts busy cycles; optionally pulses a MULT start while busy.
    task automatic count_busy(input int inject_at, output int n);
        n = 0;
        while (busy && n < 40) begin
            if (n == inject_at) begin
                start = 1'b1;
                mdop  = MD_MULT;
                numa  = 32'd5;
                numb  = 32'd5;
            end else begin
                start = 1'b0;
            end
            n++;
            @(posedge clk); #1;
        end
        start = 1'b0;
        mdop  = MD_NONE;
    endtask

    initial begin
        int n;
        @(posedge clk); #1;
        chk_en = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_hi", hi, 32'd0);
        check("reset_lo", lo, 32'd0);

        do_op(MD_MULT, 32'hFFFF_FFFE, 32'd3);
        count_busy(-1, n);
        check("mult_cycles", n, 32'd5);
        check("mult_hi", hi, 32'hFFFF_FFFF);
        check("mult_lo", lo, 32'hFFFF_FFFA);

        do_op(MD_MULTU, 32'hFFFF_FFFE, 32'd3);
        count_busy(-1, n);
        check("multu_cycles", n, 32'd5);
        check("multu_hi", hi, 32'h0000_0002);
        check("multu_lo", lo, 32'hFFFF_FFFA);

        do_op(MD_DIV, 32'hFFFF_FFF9, 32'd2);
        count_busy(-1, n);
        check("div_cycles", n, 32'd10);
        check("div_lo", lo, 32'hFFFF_FFFD);
        check("div_hi", hi, 32'hFFFF_FFFF);

        do_op(MD_DIVU, 32'd7, 32'd2);
        count_busy(-1, n);
        check("divu_lo", lo, 32'd3);
        check("divu_hi", hi, 32'd1);

        do_op(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        count_busy(-1, n);
        check("divovf_lo", lo, 32'h8000_0000);
        check("divovf_hi", hi, 32'd0);

        do_op(MD_MTHI, 32'h1234_5678, 32'd0);
        check("mthi_hi", hi, 32'h1234_5678);
        check("mthi_busy", {31'd0, busy}, 32'd0);
        do_op(MD_MTLO, 32'h9ABC_DEF0, 32'd0);
        check("mtlo_lo", lo, 32'h9ABC_DEF0);
        check("mtlo_hi", hi, 32'h1234_5678);

        do_op(MD_MTHI, 32'hAA, 32'd0);
        do_op(MD_MTLO, 32'hBB, 32'd0);
        do_op(MD_DIV, 32'd1234, 32'd0);
        count_busy(3, n);
        check("divzero_cycles", n, 32'd10);
        check("divzero_hi", hi, 32'hAA);
        check("divzero_lo", lo, 32'hBB);
        @(posedge clk); #1;
        check("ignored_start_busy", {31'd0, busy}, 32'd0);

        do_op(MD_DIV, 32'd100, 32'd7);
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("midreset_busy", {31'd0, busy}, 32'd0);
        check("midreset_hi", hi, 32'd0);
        check("midreset_lo", lo, 32'd0);
        repeat (15) @(posedge clk);
        #1;
        check("midreset_nocommit_lo", lo, 32'd0);

        reset = 1'b1;
        do_op(MD_MTHI, 32'h55, 32'd0);
        reset = 1'b0;
        check("reset_wins_hi", hi, 32'd0);

        do_op(MD_NONE, 32'h1111, 32'h2222);
        do_op(4'd15, 32'h3333, 32'h4444);
        check("noop_busy", {31'd0, busy}, 32'd0);

        do_op(MD_MTHI, 32'd0, 32'd0);
        do_op(MD_MTLO, 32'hFFFF_FFFF, 32'd0);
        do_op(MD_MADDU, 32'd1, 32'd1);
        count_busy(-1, n);
`ifdef MDU_MADD_EN
        check("maddu_cycles", n, 32'd5);
        check("maddu_hi", hi, 32'd1);
        check("maddu_lo", lo, 32'd0);
        do_op(MD_MSUB, 32'd2, 32'd3);
        count_busy(-1, n);
        check("msub_hi", hi, 32'd0);
        check("msub_lo", lo, 32'hFFFF_FFFA);
`else
        check("maddu_cycles", n, 32'd0);
        check("maddu_hi", hi, 32'd0);
        check("maddu_lo", lo, 32'hFFFF_FFFF);
`endif

        repeat (2) @(posedge clk);
        #1;
        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/md_unit.md
# md_unit

Multiply/divide unit for the EX stage of the pipelined CPU. It sits beside the ALU and receives the same forwarded operand pair. Its HI/LO outputs feed the EX-stage result mux together with the ALU output. It models multi-cycle MULT/DIV latency with a busy flag, which the hazard unit uses to stall multiply/divide-class instructions in ID.

## Interface
- MULT_LAT, 5: cycles busy is held after a multiply-class start.
- DIV_LAT, 10: cycles busy is held after a divide-class start.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- numa  in  32  operand A (rs), forwarded value.
- numb  in  32  operand B (rt), forwarded value.
- mdop  in  4  operation code. 0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7–10 see Configuration.
- start  in  1  sample mdop/numa/numb this cycle.
- busy  out  1  a multi-cycle operation is in flight.
- hi  out  32  architectural HI.
- lo  out  32  architectural LO.

## Operation
- States: IDLE and BUSY. A 4-bit counter `cnt` counts down the remaining busy cycles.
- Reset values: busy=0, hi=0, lo=0, state IDLE, cnt=0, pending registers cleared.
- IDLE with start=1 and mdop in 1..4:
  - Compute the full result from numa/numb in the same cycle.
  - Latch it into phi/plo.
  - Load cnt with MULT_LAT (ops 1, 2) or DIV_LAT (ops 3, 4). Go to BUSY.
- BUSY:
  - Decrement cnt each cycle.
  - On the cycle where cnt==1, commit phi→hi and plo→lo and return to IDLE.
- MULT: signed 32×32→64. {hi,lo} = product. MULTU is the same, unsigned.
- DIV: signed. lo = quotient truncated toward zero. hi = remainder, carrying the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
- DIVU: unsigned quotient and remainder.
- Divide by zero (numb==0, op 3 or 4):
  - busy is still asserted for DIV_LAT cycles.
  - hi/lo remain unchanged at commit.
- MTHI/MTLO with start=1 in IDLE:
  - hi (or lo) = numa at the next edge.
  - busy stays 0 and there is no BUSY entry.
- start=1 while busy=1: ignored entirely. The hazard unit guarantees this does not happen; the bench checks that it is ignored.
- mdop=0 or an unsupported code with start=1: no effect.
- start=0: mdop and operands are ignored.

## Timing
- Start sampled at edge E0:
  - busy=1 from E0 through E0+LAT−1, i.e. LAT cycles.
  - hi/lo update and busy falls at edge E0+LAT.
- The hi/lo values visible during busy are the old values.
- Back-to-back: a new start is accepted in the first cycle busy=0 after commit.
- MTHI/MTLO: one-cycle latency. The new value is visible the cycle after the start.
- Reset asserted mid-operation:
  - At that edge the pending result is discarded.
  - busy=0, hi=lo=0, cnt=0.
- reset and start both high: reset wins.

## Configuration
- Macro `MDU_MADD_EN`.
- Defined: adds four opcodes, all with MULT_LAT latency:
  - 7 MADD: {hi,lo} += signed product.
  - 8 MADDU: unsigned variant of MADD.
  - 9 MSUB: {hi,lo} −= signed product.
  - 10 MSUBU: unsigned variant of MSUB.
  - The accumulate uses the hi/lo value current at start, computed mod 2^64.
- Undefined: codes 7–10 are treated as NONE.

## Structure
- Shared package `md_defs`:
  - mdop encodings MD_NONE…MD_MSUBU.
  - Default latency constants.
  - The decoder and hazard unit use the same package.
- No sub-module is needed. Arithmetic is a single combinational block feeding phi/plo, and the FSM/counter sit in the top module.

## Test plan
- Reset, then MULT with numa=0xFFFFFFFE (−2), numb=3 → busy for exactly 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA. MULTU on the same operands → hi=0x00000002, lo=0xFFFFFFFA.
- DIV with numa=0xFFFFFFF9 (−7), numb=2 → busy for 10 cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 7/2 → lo=3, hi=1.
- MTHI numa=0x12345678, next cycle MTLO numa=0x9ABCDEF0 → hi and lo each updated one cycle after its start, busy never high.
- DIV by zero with hi=0xAA, lo=0xBB preloaded → busy for 10 cycles, hi/lo still 0xAA/0xBB afterwards. A start during busy is ignored and hi/lo are unchanged by it.
- Reset asserted on cycle 3 of a DIV → busy=0, hi=lo=0 the next cycle, and no later commit.
- With `MDU_MADD_EN`: hi=0, lo=0xFFFFFFFF, then MADDU 1×1 → hi=1, lo=0. Without the macro, the same sequence leaves hi/lo unchanged.
